// File: rtl/dmem_sized_if.sv
// Load/store request and response bundle between the core LSU and dmem_sized.
// ready/req form the handshake; rvalid/rdata/fault return one cycle after acceptance.
interface dmem_sized_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        fault;

    modport master (
        output req, we, size, unsigned_ld, addr, wdata,
        input  ready, rvalid, rdata, fault
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata,
        output ready, rvalid, rdata, fault
    );
endinterface

// File: rtl/dmem_sized.sv
// Sized data memory: byte/half/word stores with lane masks, extended loads, post-reset clear sweep.
// Latency: 1 cycle from acceptance to rvalid; ready low for DEPTH cycles after reset.
// Backpressure: none in RUN (one access/cycle); optional DMEM_SIZED_RANGE_CHECK_EN faults out-of-range addresses.
module dmem_sized #(
    parameter int          DEPTH      = 64,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    dmem_sized_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            rvalid_q, rvalid_d;
    logic            fault_q, fault_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            misalign;
    logic            range_err;
    logic            bad;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [31:0]     wrep;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [31:0]     ld_data;

    assign idx    = bus.addr[AW+1:2];
    assign lane   = bus.addr[1:0];
    assign accept = bus.req && (state_q == ST_RUN);

    always_comb begin
        misalign = 1'b0;
        case (bus.size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = bus.addr[0];
            2'b10:   misalign = (lane != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

`ifdef DMEM_SIZED_RANGE_CHECK_EN
    assign range_err = |bus.addr[31:AW+2];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:AW+2];
    assign range_err      = 1'b0;
`endif

    assign bad = misalign || range_err;

    // Byte enables and lane-replicated write data so every lane sees its own slice.
    always_comb begin
        be   = 4'b0000;
        wrep = bus.wdata;
        case (bus.size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wrep = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                be   = bus.addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{bus.wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        ld_data = rd_word;
        case (bus.size)
            2'b00:   ld_data = {{24{~bus.unsigned_ld & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   ld_data = {{16{~bus.unsigned_ld & rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    // Array has no reset of its own; the CLEAR sweep is its only initialisation.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= INIT_VALUE;
        end else if (accept && bus.we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wrep[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase

        rvalid_d = accept;
        fault_d  = accept && bad;
        rdata_d  = (accept && !bad && !bus.we) ? ld_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            rvalid_q  <= 1'b0;
            fault_q   <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rvalid_q  <= rvalid_d;
            fault_q   <= fault_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.ready  = (state_q == ST_RUN);
    assign bus.rvalid = rvalid_q;
    assign bus.fault  = fault_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_dmem_sized.sv
// Randomised + directed bench for dmem_sized with a byte-level reference memory and a response scoreboard.
module tb_dmem_sized;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_sized_if bus();

    dmem_sized #(.DEPTH(64), .INIT_VALUE(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] model [64];

    typedef struct {
        logic        f;
        logic [31:0] d;
        int          tag;
    } exp_t;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_fault(input logic [1:0] size, input logic [31:0] addr);
        bit f;
        f = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`ifdef DMEM_SIZED_RANGE_CHECK_EN
        if (addr[31:8] != 24'h0) f = 1'b1;
`endif
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
    endtask

    // Drive one access at a negedge; if it will be accepted, update the model and queue the response.
    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit use_k, input logic [31:0] k);
        int          idx;
        int          sh;
        logic [31:0] m;
        logic [31:0] v;
        exp_t        e;
        bus.req         = 1'b1;
        bus.we          = we;
        bus.size        = size;
        bus.unsigned_ld = uns;
        bus.addr        = addr;
        bus.wdata       = wdata;
        if (bus.ready) begin
            idx = int'(addr[7:2]);
            sh  = 8 * int'(addr[1:0]);
            m   = (size == 2'b00) ? 32'hFF : (size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
            e.tag = cyc + 1;
            e.f   = 1'b0;
            e.d   = 32'h0;
            if (is_fault(size, addr)) begin
                e.f = 1'b1;
            end else if (we) begin
                model[idx] = (model[idx] & ~(m << sh)) | ((wdata & m) << sh);
            end else begin
                v = (model[idx] >> sh) & m;
                if (!uns && size != 2'b10 && (v & ((m >> 1) + 1)) != 0) v = v | ~m;
                e.d = v;
            end
            if (use_k) e.d = k;
            sbq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req   = 1'b0;
        bus.we    = 1'($urandom);
        bus.addr  = $urandom;
        bus.wdata = $urandom;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        checks++;
        if (bus.ready !== 1'b0 || bus.rvalid !== 1'b0 || bus.fault !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rvalid=%b fault=%b rdata=%h, required 0/0/0/0",
                     bus.ready, bus.rvalid, bus.fault, bus.rdata);
        end
    endtask

    task automatic do_reset(input int hold);
        reset   = 1'b1;
        bus.req = 1'b0;
        repeat (hold) @(negedge clk);
        check_reset_outputs();
        model_clear();
        reset = 1'b0;
    endtask

    task automatic check_ready_delay(input string name);
        int n;
        n = 0;
        while (!bus.ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL %s: ready low for %0d cycles, required 64", name, n);
        end
    endtask

    // Monitor: every negedge, compare the presented response with the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.rvalid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: cyc=%0d fault=%b rdata=%h, required no response", cyc, bus.fault, bus.rdata);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (bus.fault !== e.f || bus.rdata !== e.d || e.tag != cyc) begin
                    errors++;
                    $display("FAIL response: cyc=%0d fault=%b rdata=%h, required cyc=%0d fault=%b rdata=%h",
                             cyc, bus.fault, bus.rdata, e.tag, e.f, e.d);
                end
            end
        end else begin
            checks++;
            if (bus.fault !== 1'b0 || bus.rdata !== 32'h0) begin
                errors++;
                $display("FAIL idle_outputs: cyc=%0d fault=%b rdata=%h, required 0/0", cyc, bus.fault, bus.rdata);
            end
            if (sbq.size() != 0 && sbq[0].tag <= cyc) begin
                exp_t e;
                e = sbq.pop_front();
                errors++;
                $display("FAIL missing_rvalid: cyc=%0d rvalid=0, required response fault=%b rdata=%h", cyc, e.f, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.unsigned_ld = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        model_clear();
        @(negedge clk);

        // Reset, then hold a word load at 0xFC through the clear sweep.
        do_reset(3);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.addr = 32'h0FC;
        check_ready_delay("clear_after_reset");
        drive(1'b0, 2'b10, 1'b0, 32'h0FC, 32'h0, 1'b1, 32'h0);
        idle();

        // Sub-word store merge, then extended loads.
        drive(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 1'b1, 32'h0);
        drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000011, 1'b1, 32'h0);
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h889911BB);
        drive(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFF88);
        drive(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 32'h00000088);
        drive(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 32'hFFFF8899);
        drive(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1, 32'h000011BB);
        idle();

        // Misaligned and reserved accesses leave memory untouched.
        drive(1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, 1'b1, 32'h0);
        drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0);
        drive(1'b0, 2'b11, 1'b0, 32'h0,  32'h0, 1'b1, 32'h0);
        drive(1'b1, 2'b01, 1'b0, 32'h31, 32'hFFFF, 1'b1, 32'h0);
        idle();

        // Reset pulse in the middle of the clear sweep restarts it.
        drive(1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 32'h0);
        idle();
        do_reset(1);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check_ready_delay("clear_after_midclear_reset");
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        idle();

        // Address above DEPTH words: range fault or modulo wrap.
        drive(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 1'b0, 32'h0);
`ifdef DMEM_SIZED_RANGE_CHECK_EN
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
`else
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 32'h12345678);
`endif
        idle();

        // Random traffic, back-to-back and gapped, checked against the reference memory.
        repeat (500) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                logic [31:0] a;
                logic [1:0]  s;
                a = {24'h0, 8'($urandom)};
                if ($urandom_range(0, 7) == 0) a[31:8] = 24'($urandom);
                s = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                drive(1'($urandom), s, 1'($urandom), a, $urandom, 1'b0, 32'h0);
            end
        end
        repeat (4) idle();

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
